// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//
// Read-side master for a simple dual-port block RAM with a one-cycle
// registered read port. On start it streams `count` words beginning at `base`
// (address wraps modulo 2^ADDR_W) out as a valid/ready stream with a last flag.
//
// A small output FIFO absorbs downstream backpressure. A read is issued only
// while (fifo occupancy + reads in flight) < FIFO_DEPTH, so every word that
// comes back from the RAM is guaranteed a free FIFO slot.
//
// Optional feature (compile-time macro BRAM_STREAM_READER_CSUM_EN):
//   adds output `csum`, the running XOR of all words accepted downstream in
//   the current transfer. It clears on an accepted start and on reset.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   begin transfer; only looked at while busy=0
//   base       in   first read address, captured with start
//   count      in   number of words (0 .. 2^ADDR_W), captured with start
//   busy       out  transfer in progress
//   done       out  one-cycle pulse after the last word is accepted
//   rdaddress  out  registered RAM read address
//   q          in   RAM read data, valid one cycle after rdaddress
//   out_data   out  stream data (FIFO head, 0 while the FIFO is empty)
//   out_valid  out  stream valid
//   out_ready  in   stream ready
//   out_last   out  final word of the transfer
//   csum       out  (macro only) XOR of accepted words
// ---------------------------------------------------------------------------
module bram_stream_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef BRAM_STREAM_READER_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Occupancy needs one extra bit to represent a completely full FIFO.
  localparam int OCC_W = PTR_W + 1;
  // Width used for the credit sum (occupancy + up to two in-flight reads).
  localparam int CRD_W = OCC_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
  localparam logic [CRD_W-1:0]  CRD_MAX  = CRD_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] rdaddr_q;      // address currently presented to the RAM
  logic [ADDR_W-1:0] next_addr_q;   // next address to issue
  logic [ADDR_W:0]   issue_left_q;  // reads still to be issued
  logic [ADDR_W:0]   pop_left_q;    // words still to be accepted downstream

  // Read pipeline: stage 1 = address presented this cycle,
  // stage 2 = RAM data on q this cycle (pushed into the FIFO at the edge).
  logic              rd_v1_q;
  logic              rd_v2_q;

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;

  logic              push;
  logic              pop;
  logic [CRD_W-1:0]  credit_used;
  logic              credit_ok;

  assign push = rd_v2_q;
  assign pop  = out_valid && out_ready;

  // Every read in flight already owns a FIFO slot, so the sum below can never
  // exceed FIFO_DEPTH once its data lands.
  assign credit_used = CRD_W'(occ_q) + CRD_W'(rd_v1_q) + CRD_W'(rd_v2_q);
  assign credit_ok   = credit_used < CRD_MAX;

  // NOTE: every signal assigned in always_comb gets a default on the first
  // line so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;   // idle, or push and pop cancel out
    endcase
  end

  // NOTE: the FIFO storage has no reset; its contents are only observable
  // through out_data, which is gated by out_valid, and the pointers/occupancy
  // that qualify it are reset. This keeps the array mappable to plain RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= q;
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples the pre-edge value of its inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      occ_q <= occ_d;
    end
  end

  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  // pop_left_q only moves on a handshake, so out_last is stable during stalls.
  assign out_last  = out_valid && (pop_left_q == CNT_ONE);

  // -------------------------------------------------------------------------
  // Transfer FSM with its counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdaddr_q     <= '0;
      next_addr_q  <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      rd_v1_q      <= 1'b0;
      rd_v2_q      <= 1'b0;
    end else begin
      // Defaults: done is a pulse, stage 1 only holds an address issued at
      // this edge, stage 2 follows stage 1 one cycle later.
      done_q  <= 1'b0;
      rd_v1_q <= 1'b0;
      rd_v2_q <= rd_v1_q;
      if (pop) begin
        pop_left_q <= pop_left_q - CNT_ONE;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count == '0) begin
              // Empty transfer: acknowledge with done, never become busy.
              done_q <= 1'b1;
            end else begin
              // The first read is issued straight from IDLE so rdaddress
              // shows base right after the start edge.
              rdaddr_q     <= base;
              next_addr_q  <= base + ADDR_ONE;
              rd_v1_q      <= 1'b1;
              issue_left_q <= count - CNT_ONE;
              pop_left_q   <= count;
              busy_q       <= 1'b1;
              state_q      <= (count == CNT_ONE) ? S_DRAIN : S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (credit_ok) begin
            rdaddr_q     <= next_addr_q;
            next_addr_q  <= next_addr_q + ADDR_ONE;  // wraps naturally
            rd_v1_q      <= 1'b1;
            issue_left_q <= issue_left_q - CNT_ONE;
            if (issue_left_q == CNT_ONE) begin
              state_q <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // Accepting the last word implies every read has landed and the
          // FIFO has emptied, so this single condition ends the transfer.
          if (pop && out_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdaddress = rdaddr_q;

`ifdef BRAM_STREAM_READER_CSUM_EN
  // -------------------------------------------------------------------------
  // Running XOR of accepted words; holds after done until the next start.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q ^ out_data;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
//
// Self-checking bench for bram_stream_reader. A behavioural RAM with a
// one-cycle registered read feeds the DUT. Expected stream contents come from
// a queue built directly from the RAM image (word i = ram[(base+i) mod 512]),
// and every accepted beat is compared against it, together with start
// latency, address order, stall stability, last flag and done timing.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
`ifdef BRAM_STREAM_READER_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] ram [DEPTH];

  always #5 clock = ~clock;

  // Behavioural RAM: address sampled at the edge, data on q the next cycle.
  always @(posedge clock) q <= ram[rdaddress];

  bram_stream_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rdaddress(rdaddress),
    .q        (q),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
`ifdef BRAM_STREAM_READER_CSUM_EN
    ,
    .csum     (csum)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 0: always ready, 1: pattern 1,0,0,1,0,0..., 2: random
  function automatic logic ready_for(input int mode, input int n);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (n % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_done"},      64'(done),      64'(0));
    check({tag, "_rdaddress"}, 64'(rdaddress), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_last"},  64'(out_last),  64'(0));
    check({tag, "_out_data"},  64'(out_data),  64'(0));
  endtask

  // Runs one transfer and scoreboards it. inject=1 pulses a second start
  // while busy; abort_after>0 asserts reset after that many accepted beats.
  task automatic run_transfer(input int b, input int c, input int mode,
                              input bit inject, input int abort_after);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_word;
    logic [DATA_W-1:0] xsum;
    logic [DATA_W-1:0] prev_data;
    logic              prev_valid;
    logic              prev_ready;
    logic              prev_last;
    int n;
    int hs;
    int first_valid;
    int last_hs_n;
    int budget;
    bit finished;

    xsum = '0;
    for (int i = 0; i < c; i++) exp_q.push_back(ram[(b + i) % DEPTH]);

    @(posedge clock); #1;
    start = 1'b1;
    base  = ADDR_W'(b);
    count = (ADDR_W + 1)'(c);
    out_ready = 1'b1;
    @(posedge clock);   // start is sampled here (edge 0)
    #1;

    n = 0; hs = 0; first_valid = -1; last_hs_n = -1;
    budget = c * 8 + 40;
    finished = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;

    while (!finished && n < budget) begin
      out_ready = ready_for(mode, n);
      if (inject && n == 3) begin
        start = 1'b1;
        base  = ADDR_W'(b + 77);
        count = (ADDR_W + 1)'(5);
      end else begin
        start = 1'b0;
      end

      @(negedge clock);
      if (n == 0) begin
        check("busy_after_start", 64'(busy), 64'(1));
        check("rdaddr_first", 64'(rdaddress), 64'(b % DEPTH));
      end
      if (mode == 0 && n < c)
        check("rdaddr_seq", 64'(rdaddress), 64'((b + n) % DEPTH));
      if (out_valid && first_valid < 0) begin
        first_valid = n;
        check("first_valid_latency", 64'(n), 64'(2));
      end
      if (prev_valid && !prev_ready) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data",  64'(out_data),  64'(prev_data));
        check("stall_last",  64'(out_last),  64'(prev_last));
      end

      if (last_hs_n >= 0 && n == last_hs_n + 1) begin
        check("done_pulse", 64'(done), 64'(1));
        check("busy_clear", 64'(busy), 64'(0));
`ifdef BRAM_STREAM_READER_CSUM_EN
        check("csum_final", 64'(csum), 64'(xsum));
`endif
        finished = 1'b1;
      end else if (done) begin
        check("unexpected_done", 64'(done), 64'(0));
      end

      if (!finished && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(1), 64'(0));
        end else begin
          exp_word = exp_q.pop_front();
          check("data", 64'(out_data), 64'(exp_word));
          check("last", 64'(out_last), 64'(exp_q.size() == 0));
          xsum = xsum ^ exp_word;
          hs++;
          if (exp_q.size() == 0) last_hs_n = n;
        end
        if (abort_after > 0 && hs == abort_after) begin
          // Let this beat be accepted, then reset mid-cycle.
          @(posedge clock); #1;
          reset = 1'b1;
          #1;
          check_reset_outputs("abort");
          @(posedge clock); #1;
          reset = 1'b0;
          start = 1'b0;
          for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("abort_no_done", 64'(done), 64'(0));
            check("abort_idle", 64'(out_valid), 64'(0));
          end
          return;
        end
      end

      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      @(posedge clock); #1;
      n++;
    end

    start = 1'b0;
    if (!finished) begin
      check("transfer_timeout", 64'(n), 64'(budget + 1));
    end else begin
      check("all_words_seen", 64'(hs), 64'(c));
      @(negedge clock);
      check("done_single_cycle", 64'(done), 64'(0));
`ifdef BRAM_STREAM_READER_CSUM_EN
      check("csum_hold", 64'(csum), 64'(xsum));
`endif
    end
  endtask

  task automatic run_empty(input int b);
    logic [ADDR_W-1:0] addr_before;
    @(posedge clock); #1;
    addr_before = rdaddress;
    start = 1'b1;
    base  = ADDR_W'(b);
    count = '0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("empty_done", 64'(done), 64'(1));
    check("empty_busy", 64'(busy), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("empty_done_once", 64'(done),      64'(0));
      check("empty_no_valid",  64'(out_valid), 64'(0));
      check("empty_rdaddr",    64'(rdaddress), 64'(addr_before));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) ram[k] = $urandom();
    for (int k = 0; k < 8; k++) ram[k] = 32'(k) * 32'h0101_0101;
    ram[100] = 32'hDEAD_BEEF;
    ram[101] = 32'h1234_5678;

    reset = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Basic streaming at full rate, then with the 1,0,0 ready pattern.
    run_transfer(0, 8, 0, 1'b0, 0);
    run_transfer(0, 8, 1, 1'b0, 0);
    // Address wrap.
    run_transfer(510, 4, 0, 1'b0, 0);
    // Empty transfer, then a start pulse while busy.
    run_empty(5);
    run_transfer(0, 8, 0, 1'b1, 0);
    // Reset mid-transfer, then a clean short transfer.
    run_transfer(0, 8, 0, 1'b0, 3);
    run_transfer(4, 2, 0, 1'b0, 0);
    // Checksum pair.
    run_transfer(100, 2, 0, 1'b0, 0);
`ifdef BRAM_STREAM_READER_CSUM_EN
    check("csum_known", 64'(csum), 64'(32'hCC99_E897));
`endif
    // Single word and a full-memory transfer.
    run_transfer(511, 1, 2, 1'b0, 0);
    run_transfer(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 1'b0, 0);
    // Random transfers with random backpressure.
    for (int t = 0; t < 8; t++)
      run_transfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 24)),
                   2, 1'($urandom_range(0, 1)), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
